// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the single-cycle MIPS32 core: preloads memories,
// releases the core, counts run cycles and stops on HALT or timeout.
`timescale 1ns/1ps
module cpu_run_ctrl #(
    parameter int          IMEM_AW   = 8,
    parameter int          DMEM_AW   = 8,
    parameter int          DMEM_BASE = 16,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [31:0]        ld_data,
    input  logic               ld_sel,
    input  logic               ld_last,
    input  logic [CNT_W-1:0]   timeout_limit,
    input  logic [31:0]        cpu_instr,
    input  logic [31:0]        cpu_pc,
    output logic               cpu_reset,
    output logic               cpu_en,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_waddr,
    output logic [31:0]        mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic               timeout,
    output logic               ovf_err,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [31:0]        halt_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [IMEM_AW-1:0] IMAX  = '1;
    localparam logic [DMEM_AW-1:0] DMAX  = '1;
    localparam logic [DMEM_AW-1:0] DBASE = DMEM_AW'(DMEM_BASE);
    localparam logic [CNT_W-1:0]   CMAX  = '1;

    state_t             state;
    logic [IMEM_AW-1:0] iptr;
    logic [DMEM_AW-1:0] dptr;
    logic               ifull;
    logic               dfull;

    logic accept;
    logic halt_hit;
    logic limit_hit;

    assign accept    = ld_valid & ld_ready;
    assign halt_hit  = (cpu_instr == HALT_WORD);
    assign limit_hit = (timeout_limit != '0) &&
                       (cycle_count == timeout_limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            iptr        <= '0;
            dptr        <= '0;
            ifull       <= 1'b0;
            dfull       <= 1'b0;
            ld_ready    <= 1'b0;
            cpu_reset   <= 1'b1;
            cpu_en      <= 1'b0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            dmem_we     <= 1'b0;
            dmem_waddr  <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            ovf_err     <= 1'b0;
            cycle_count <= '0;
            halt_pc     <= '0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        ld_ready    <= 1'b1;
                        busy        <= 1'b1;
                        cpu_reset   <= 1'b1;
                        cpu_en      <= 1'b0;
                        iptr        <= '0;
                        dptr        <= DBASE;
                        ifull       <= 1'b0;
                        dfull       <= 1'b0;
                        cycle_count <= '0;
                        done        <= 1'b0;
                        halted      <= 1'b0;
                        timeout     <= 1'b0;
                        ovf_err     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        mem_wdata <= ld_data;
                        // Full pointers park at the top address.
                        if (!ld_sel) begin
                            if (ifull) begin
                                ovf_err <= 1'b1;
                            end else begin
                                imem_we    <= 1'b1;
                                imem_waddr <= iptr;
                                if (iptr == IMAX) ifull <= 1'b1;
                                else iptr <= iptr + 1'b1;
                            end
                        end else begin
                            if (dfull) begin
                                ovf_err <= 1'b1;
                            end else begin
                                dmem_we    <= 1'b1;
                                dmem_waddr <= dptr;
                                if (dptr == DMAX) dfull <= 1'b1;
                                else dptr <= dptr + 1'b1;
                            end
                        end
                        if (ld_last) begin
                            state    <= S_RELEASE;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                S_RELEASE: begin
                    state     <= S_RUN;
                    cpu_reset <= 1'b0;
                    cpu_en    <= 1'b1;
                end
                S_RUN: begin
                    // Count freezes at the value that ended the run.
                    if (halt_hit || limit_hit) begin
                        state   <= S_DONE;
                        cpu_en  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        halted  <= halt_hit;
                        timeout <= !halt_hit;
                        halt_pc <= cpu_pc;
                    end else if (cycle_count != CMAX) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
